// File: rtl/bus_handoff_rx_mc.sv
// bus_handoff_rx_mc: per-channel toggle-handshake receivers merged round-robin onto one valid/ready stream.
// Each channel holds at most one word; the ack toggle flips when that word is accepted downstream.
module bus_handoff_rx_mc #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CH_W        = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       req_toggle,
  input  logic [CHANNELS*WIDTH-1:0] bus_in,
  output logic [CHANNELS-1:0]       ack_toggle,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [CH_W-1:0]           out_chan,
  output logic [CHANNELS-1:0]       overrun,
  input  logic [CHANNELS-1:0]       clr_overrun
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                                state_q, state_d;
  logic [SYNC_STAGES-1:0][CHANNELS-1:0]  sync_q, sync_d;
  logic [CHANNELS-1:0]                   hist_q, hist_d;
  logic [CHANNELS-1:0]                   full_q, full_d;
  logic [CHANNELS-1:0]                   ack_q, ack_d;
  logic [CHANNELS-1:0]                   ovr_q, ovr_d;
  logic [CHANNELS-1:0][WIDTH-1:0]        slot_q, slot_d;
  logic [WIDTH-1:0]                      data_q, data_d;
  logic [CH_W-1:0]                       chan_q, chan_d;
  logic [CH_W-1:0]                       rr_q, rr_d;
  logic [CH_W-1:0]                       gnt;
  logic [CHANNELS-1:0]                   evt;
  logic [CHANNELS-1:0]                   avail;
  logic                                  accept;
  logic                                  hold;
  logic                                  found;
  int                                    idx;

  always_comb begin
    accept = (state_q == HOLD) && out_ready;
    hold   = (state_q == HOLD) && !out_ready;
    sync_d = {sync_q[SYNC_STAGES-2:0], req_toggle};
    hist_d = sync_q[SYNC_STAGES-1];
    evt    = sync_q[SYNC_STAGES-1] ^ hist_q;
    full_d = full_q;
    slot_d = slot_q;
    ack_d  = ack_q;
    avail  = full_q;
    // an edge into an occupied slot (even one being freed now) is a sender protocol violation
    ovr_d  = (ovr_q & ~clr_overrun) | (evt & full_q);
    for (int c = 0; c < CHANNELS; c++) begin
      if (evt[c] && !full_q[c]) begin
        full_d[c] = 1'b1;
        slot_d[c] = bus_in[c*WIDTH +: WIDTH];
      end
    end
    if (accept) begin
      full_d[chan_q] = 1'b0;
      ack_d[chan_q]  = ~ack_q[chan_q];
      avail[chan_q]  = 1'b0;
    end
    rr_d  = accept ? CH_W'((int'(chan_q) + 1) % CHANNELS) : rr_q;
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = (int'(rr_d) + i) % CHANNELS;
      if (!found && avail[idx]) begin
        found = 1'b1;
        gnt   = CH_W'(idx);
      end
    end
    state_d = (hold || found) ? HOLD : IDLE;
    data_d  = (hold || !found) ? data_q : slot_q[gnt];
    chan_d  = (hold || !found) ? chan_q : gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q  <= '0;
      hist_q  <= '0;
      full_q  <= '0;
      ack_q   <= '0;
      ovr_q   <= '0;
      slot_q  <= '0;
      data_q  <= '0;
      chan_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      full_q  <= full_d;
      ack_q   <= ack_d;
      ovr_q   <= ovr_d;
      slot_q  <= slot_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      rr_q    <= rr_d;
    end
  end

  assign ack_toggle = ack_q;
  assign out_valid  = (state_q == HOLD);
  assign out_data   = data_q;
  assign out_chan   = chan_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_bus_handoff_rx_mc.sv
// tb_bus_handoff_rx_mc: directed and random stimulus against a transaction-level reference model.
module tb_bus_handoff_rx_mc;
  localparam int W  = 8;
  localparam int CH = 4;
  localparam int SS = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [CH-1:0]     req_toggle = '0;
  logic [CH*W-1:0]   bus_in = '0;
  logic [CH-1:0]     ack_toggle;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [W-1:0]      out_data;
  logic [1:0]        out_chan;
  logic [CH-1:0]     overrun;
  logic [CH-1:0]     clr_overrun = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_tog [CH];

  typedef struct {int due; int ch; logic [W-1:0] d;} ev_t;
  ev_t evq[$];

  typedef struct packed {
    logic              valid;
    logic [W-1:0]      data;
    logic [1:0]        chan;
    logic [1:0]        rr;
    logic [CH-1:0]     full;
    logic [CH-1:0]     ack;
    logic [CH-1:0]     ovr;
    logic [CH-1:0][W-1:0] slot;
  } ms_t;
  ms_t m = '0;

  bus_handoff_rx_mc #(.WIDTH(W), .CHANNELS(CH), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .req_toggle(req_toggle), .bus_in(bus_in),
    .ack_toggle(ack_toggle), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chan(out_chan), .overrun(overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [CH-1:0] ev_mask(int n);
    logic [CH-1:0] r = '0;
    foreach (evq[i]) if (evq[i].due == n) r[evq[i].ch] = 1'b1;
    return r;
  endfunction

  function automatic logic [CH-1:0][W-1:0] ev_data(int n);
    logic [CH-1:0][W-1:0] r = '0;
    foreach (evq[i]) if (evq[i].due == n) r[evq[i].ch] = evq[i].d;
    return r;
  endfunction

  // one clock edge of the receiver, expressed as the spec's capture/overrun/accept/grant rules
  function automatic ms_t nxt(ms_t s, logic rdy, logic [CH-1:0] clr, logic [CH-1:0] ev,
                              logic [CH-1:0][W-1:0] evd);
    ms_t n = s;
    logic acc = s.valid && rdy;
    logic [CH-1:0] avail = s.full;
    bit got = 0;
    int g;
    n.ovr = (s.ovr & ~clr) | (ev & s.full);
    for (int c = 0; c < CH; c++)
      if (ev[c] && !s.full[c]) begin
        n.full[c] = 1'b1;
        n.slot[c] = evd[c];
      end
    if (acc) begin
      n.full[s.chan] = 1'b0;
      n.ack[s.chan]  = ~s.ack[s.chan];
      avail[s.chan]  = 1'b0;
      n.rr = 2'((s.chan + 1) % CH);
    end
    if (!s.valid || acc) begin
      n.valid = 1'b0;
      for (int i = 0; i < CH; i++) begin
        g = (n.rr + i) % CH;
        if (!got && avail[g]) begin
          got = 1;
          n.valid = 1'b1;
          n.data = s.slot[g];
          n.chan = 2'(g);
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) m <= nxt(m, out_ready, clr_overrun, ev_mask(cyc + 1), ev_data(cyc + 1));
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", 32'(out_valid), 32'(m.valid));
      chk("data", 32'(out_data), 32'(m.data));
      chk("chan", 32'(out_chan), 32'(m.chan));
      chk("ack", 32'(ack_toggle), 32'(m.ack));
      chk("overrun", 32'(overrun), 32'(m.ovr));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tog(input int c, input logic [W-1:0] d);
    bus_in[c*W +: W] = d;
    req_toggle[c] = ~req_toggle[c];
    evq.push_back('{cyc + SS + 1, c, d});
    last_tog[c] = cyc;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    req_toggle = '0;
    bus_in = '0;
    clr_overrun = '0;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_chan", 32'(out_chan), 0);
    chk("rst_ack", 32'(ack_toggle), 0);
    chk("rst_ovr", 32'(overrun), 0);
    m = '0;
    evq.delete();
    step(2);
    rst_n = 1'b1;
    for (int c = 0; c < CH; c++) last_tog[c] = cyc;
  endtask

  initial begin
    logic [CH-1:0] seen;
    for (int c = 0; c < CH; c++) last_tog[c] = 0;
    #1;
    do_reset();

    // single word on ch2
    out_ready = 1'b1;
    tog(2, 8'hA5);
    step(3);
    chk("sw_early", 32'(out_valid), 0);
    step(1);
    chk("sw_valid", 32'(out_valid), 1);
    chk("sw_data", 32'(out_data), 32'hA5);
    chk("sw_chan", 32'(out_chan), 2);
    step(1);
    chk("sw_ack", 32'(ack_toggle[2]), 1);
    step(3);

    // all channels at once
    for (int c = 0; c < CH; c++) tog(c, 8'(8'h10 + c));
    step(10);

    // fairness between ch0 and ch3
    tog(0, 8'($urandom));
    tog(3, 8'($urandom));
    seen = m.ack;
    for (int n = 0; n < 40; n++) begin
      step(1);
      for (int c = 0; c < CH; c += 3)
        if (m.ack[c] != seen[c]) begin
          seen[c] = m.ack[c];
          tog(c, 8'($urandom));
        end
    end
    out_ready = 1'b0;
    step(8);
    out_ready = 1'b1;
    step(8);

    // backpressure on ch1
    out_ready = 1'b0;
    tog(1, 8'h5C);
    step(14);
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_data", 32'(out_data), 32'h5C);
    out_ready = 1'b1;
    step(4);

    // overrun on ch0
    out_ready = 1'b0;
    tog(0, 8'h31);
    step(5);
    tog(0, 8'h32);
    step(6);
    chk("ovr_set", 32'(overrun[0]), 1);
    chk("ovr_data", 32'(out_data), 32'h31);
    out_ready = 1'b1;
    step(3);
    clr_overrun[0] = 1'b1;
    step(1);
    clr_overrun = '0;
    step(1);
    chk("ovr_clr", 32'(overrun[0]), 0);

    // reset while ch1 is presented and ch2 is waiting
    out_ready = 1'b0;
    tog(1, 8'h77);
    step(2);
    tog(2, 8'h88);
    step(6);
    chk("mid_hold", 32'(out_valid), 1);
    do_reset();
    out_ready = 1'b1;
    step(8);
    chk("mid_idle", 32'(out_valid), 0);

    // random traffic with one mid-run reset
    for (int n = 0; n < 1500; n++) begin
      step(1);
      if (n == 700) do_reset();
      out_ready = ($urandom % 4) != 0;
      clr_overrun = ($urandom % 20 == 0) ? CH'($urandom) : '0;
      for (int c = 0; c < CH; c++)
        if (cyc - last_tog[c] >= 4 && $urandom % 6 == 0) tog(c, 8'($urandom));
    end
    out_ready = 1'b1;
    clr_overrun = '0;
    step(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_handoff_rx_mc.md
Name: bus_handoff_rx_mc

Overview:
- Multi-channel receive side of the toggle-flag bus handoff, in a single clock domain.
- CHANNELS independent senders each present a stable bus plus a req toggle from a foreign domain.
- Per channel: synchronise the toggle, capture the bus into a one-word slot, merge all slots round-robin onto one valid/ready stream.
- After the word is consumed, return an ack toggle to the sender so it can clear its busy.
- Sits between the per-domain sender logic and the single-clock aggregation fabric.

Parameters:
WIDTH, 8, data bits per channel
CHANNELS, 4, number of sender channels (2..16)
SYNC_STAGES, 2, flops in each req synchroniser (min 2)
CH_W, $clog2(CHANNELS), width of the channel index (derived, do not override)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_toggle  in  CHANNELS  per-channel request toggle from foreign domains; each transition = one new word
bus_in  in  CHANNELS*WIDTH  channel c data at [c*WIDTH +: WIDTH]; sender holds it stable from req transition until ack seen
ack_toggle  out  CHANNELS  per-channel ack toggle, flips once per consumed word
out_valid  out  1  out_data/out_chan hold a word
out_ready  in  1  downstream accepts the word this cycle
out_data  out  WIDTH  merged word
out_chan  out  CH_W  source channel of out_data
overrun  out  CHANNELS  sticky protocol-violation flags
clr_overrun  in  CHANNELS  write-1-to-clear for overrun

Behaviour:
- Reset (rst_n low, asynchronous): sync chains, edge-history flops, slots, slot_full, ack_toggle, out_valid, out_data, out_chan, overrun all go to 0. Round-robin pointer set so channel 0 wins first. Words in flight are discarded; senders must be reset together with this block.
- Synchroniser: SYNC_STAGES-deep chain per channel, plus one history flop. edge[c] = last_stage XOR history.
- Capture: edge[c] with slot_full[c]=0 -> slot[c] <= bus_in slice, slot_full[c] <= 1.
- Latency: slot_full rises SYNC_STAGES+1 clk edges after a req_toggle change that meets setup; out_valid rises one cycle after that if the output is idle.
- Overrun: edge[c] while slot_full[c]=1 (including a slot currently presented or being freed this cycle) -> overrun[c] <= 1. Data is dropped, no ack is issued, the slot is unchanged.
- clr_overrun[c] clears overrun[c]. A set on the same cycle wins.
- Output FSM:
  - IDLE (out_valid=0): if any slot_full, grant the first full channel at or after rr_ptr, load out_data/out_chan, go to HOLD.
  - HOLD (out_valid=1): out_data/out_chan stay stable while out_ready=0.
  - On out_valid&&out_ready: slot_full[out_chan] <= 0, ack_toggle[out_chan] flips, rr_ptr <= out_chan+1 (wraps CHANNELS-1 -> 0).
  - In that same cycle, if another slot is full (the freed channel is excluded), load it and stay in HOLD. Otherwise go to IDLE.
  - Sustained throughput is 1 word/cycle.
- A slot stays occupied from capture until its word is accepted downstream. At most one word per channel is in flight.
- ack_toggle is registered. The sender sees it after its own synchroniser.
- Arbitration is combinational over slot_full from rr_ptr. Starvation-free: every full channel is served within CHANNELS accepts.
- out_chan is zero-extended. Channel indices >= CHANNELS are never produced.

Test Plan:
- Single word: defaults; toggle req_toggle[2] with bus_in ch2=0xA5, out_ready=1 -> out_valid at cycle 4 with out_data=0xA5, out_chan=2; ack_toggle[2]=1 the next cycle; no overrun.
- Simultaneous: all 4 toggles flip on the same edge with data 0x10,0x11,0x12,0x13, out_ready=1 -> 4 consecutive valid cycles in order ch0..ch3; each ack flips once.
- Round-robin fairness: keep ch0 and ch3 refilled after every ack with out_ready=1 -> grants alternate 0,3,0,3; neither channel is served twice in a row while the other is full.
- Backpressure: word on ch1 with out_ready=0 for 10 cycles -> out_valid=1 and out_data/out_chan constant; ack_toggle[1] unchanged until the cycle after out_ready=1.
- Overrun: toggle ch0 twice, 5 cycles apart, with out_ready=0 -> first word held, overrun[0]=1; after out_ready only the first data emerges and ack flips once; clr_overrun[0] pulse -> overrun[0]=0.
- Reset mid-operation: ch1 in HOLD and ch2 slot full, pulse rst_n low -> all outputs 0 immediately; after release no stale word appears until a new toggle arrives.
